// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: oversampled UART receiver with configurable framing,
// latching parity, framing and break status alongside each word.
module uart_rx_cfg #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 tick,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] HALF_M1 = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_M1 = TW'(OVERSAMPLE - 1);
    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_WAIT
    } state_t;

    state_t               state_q;
    logic [1:0]           sync_q;
    logic [TW-1:0]        tick_cnt_q;
    logic [3:0]           bit_cnt_q;
    logic [DATA_BITS-1:0] shreg_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 par_bit_q;
    logic                 stop_bad_q;
    logic                 rx_done_q;
    logic                 parity_err_q;
    logic                 frame_err_q;
    logic                 break_det_q;

    logic rx_s;
    logic centre;
    logic stop_bad_d;
    logic par_bad_d;
    logic brk_d;

    assign rx_s       = sync_q[1];
    assign centre     = tick && (tick_cnt_q == FULL_M1);
    assign stop_bad_d = stop_bad_q | ~rx_s;
    assign par_bad_d  = (PARITY == 1) ? ~(^shreg_q ^ par_bit_q) :
                        (PARITY == 2) ?  (^shreg_q ^ par_bit_q) : 1'b0;
    assign brk_d      = (shreg_q == '0) && (PARITY == 0 || !par_bit_q)
                        && stop_bad_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            sync_q       <= 2'b11;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            rx_data_q    <= '0;
            par_bit_q    <= 1'b0;
            stop_bad_q   <= 1'b0;
            rx_done_q    <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            break_det_q  <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], rx};
            rx_done_q <= 1'b0;
            // bit-period counter shared by every sampled field
            if (tick && (state_q == S_DATA || state_q == S_PAR
                         || state_q == S_STOP)) begin
                tick_cnt_q <= centre ? '0 : tick_cnt_q + TW'(1);
            end
            case (state_q)
                S_IDLE: begin
                    if (!rx_s) begin
                        tick_cnt_q <= '0;
                        state_q    <= S_START;
                    end
                end
                S_START: begin
                    if (tick) begin
                        if (tick_cnt_q == HALF_M1) begin
                            tick_cnt_q <= '0;
                            if (!rx_s) begin
                                bit_cnt_q <= '0;
                                state_q   <= S_DATA;
                            end else begin
                                state_q <= S_IDLE;
                            end
                        end else begin
                            tick_cnt_q <= tick_cnt_q + TW'(1);
                        end
                    end
                end
                S_DATA: begin
                    if (centre) begin
                        shreg_q <= {rx_s, shreg_q[DATA_BITS-1:1]};
                        if (bit_cnt_q == LAST_DATA) begin
                            bit_cnt_q  <= '0;
                            stop_bad_q <= 1'b0;
                            state_q    <= (PARITY != 0) ? S_PAR : S_STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end
                end
                S_PAR: begin
                    if (centre) begin
                        par_bit_q <= rx_s;
                        state_q   <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (centre) begin
                        if (bit_cnt_q == LAST_STOP) begin
                            rx_done_q    <= 1'b1;
                            rx_data_q    <= shreg_q;
                            parity_err_q <= par_bad_d;
                            frame_err_q  <= stop_bad_d;
                            break_det_q  <= brk_d;
                            state_q <= stop_bad_d ? S_WAIT : S_IDLE;
                        end else begin
                            bit_cnt_q  <= bit_cnt_q + 4'd1;
                            stop_bad_q <= stop_bad_d;
                        end
                    end
                end
                S_WAIT: begin
                    if (rx_s) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_done    = rx_done_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign break_det  = break_det_q;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: directed frames on 8N1, 8E1 and 7O2 receivers,
// checked by a monitor draining a queue of expected words.
module tb_uart_rx_cfg;
    localparam int OS     = 16;
    localparam int BITCLK = OS * 2;

    typedef struct packed {
        logic [1:0] ch;
        logic [8:0] data;
        logic       pe;
        logic       fe;
        logic       bd;
    } exp_t;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       tick = 1'b0;
    logic       rx [3] = '{1'b1, 1'b1, 1'b1};
    logic [7:0] d0;
    logic [7:0] d1;
    logic [6:0] d2;
    logic [2:0] done;
    logic [2:0] pe;
    logic [2:0] fe;
    logic [2:0] bd;
    logic [2:0] done_prev = '0;
    exp_t       expq [$];
    int         checks = 0;
    int         errors = 0;

    uart_rx_cfg #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY(0),
                  .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst(rst), .rx(rx[0]), .tick(tick),
        .rx_data(d0), .rx_done(done[0]), .parity_err(pe[0]),
        .frame_err(fe[0]), .break_det(bd[0])
    );

    uart_rx_cfg #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY(2),
                  .STOP_BITS(1)) u_8e1 (
        .clk(clk), .rst(rst), .rx(rx[1]), .tick(tick),
        .rx_data(d1), .rx_done(done[1]), .parity_err(pe[1]),
        .frame_err(fe[1]), .break_det(bd[1])
    );

    uart_rx_cfg #(.DATA_BITS(7), .OVERSAMPLE(OS), .PARITY(1),
                  .STOP_BITS(2)) u_7o2 (
        .clk(clk), .rst(rst), .rx(rx[2]), .tick(tick),
        .rx_data(d2), .rx_done(done[2]), .parity_err(pe[2]),
        .frame_err(fe[2]), .break_det(bd[2])
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    end

    task automatic check_eq(input string name, input logic [31:0] act,
                            input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic check_word(input exp_t got);
        exp_t e;
        checks++;
        if (expq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done ch%0d: got data=%h pe=%b fe=%b bd=%b, required no output",
                     got.ch, got.data, got.pe, got.fe, got.bd);
        end else begin
            e = expq.pop_front();
            if (got !== e) begin
                errors++;
                $display("FAIL word: got ch%0d data=%h pe=%b fe=%b bd=%b, required ch%0d data=%h pe=%b fe=%b bd=%b",
                         got.ch, got.data, got.pe, got.fe, got.bd,
                         e.ch, e.data, e.pe, e.fe, e.bd);
            end
        end
    endtask

    always @(negedge clk) begin
        for (int c = 0; c < 3; c++) begin
            if (done[c]) begin
                exp_t got;
                got.ch   = 2'(c);
                got.data = (c == 0) ? 9'(d0) : (c == 1) ? 9'(d1) : 9'(d2);
                got.pe   = pe[c];
                got.fe   = fe[c];
                got.bd   = bd[c];
                check_word(got);
                checks++;
                if (done_prev[c]) begin
                    errors++;
                    $display("FAIL done_width ch%0d: high 2+ cycles, required 1", c);
                end
            end
        end
        done_prev = done;
    end

    task automatic expect_w(input int ch, input logic [8:0] d,
                            input logic p, input logic f, input logic b);
        exp_t e;
        e.ch   = 2'(ch);
        e.data = d;
        e.pe   = p;
        e.fe   = f;
        e.bd   = b;
        expq.push_back(e);
    endtask

    task automatic bitout(input int ch, input logic b);
        rx[ch] = b;
        repeat (BITCLK) @(negedge clk);
    endtask

    task automatic idle(input int ch, input int n);
        for (int i = 0; i < n; i++) bitout(ch, 1'b1);
    endtask

    task automatic send(input int ch, input int nd, input logic [8:0] d,
                        input bit haspar, input logic pb,
                        input int ns, input logic s2);
        bitout(ch, 1'b0);
        for (int i = 0; i < nd; i++) bitout(ch, d[i]);
        if (haspar) bitout(ch, pb);
        bitout(ch, 1'b1);
        if (ns == 2) bitout(ch, s2);
        rx[ch] = 1'b1;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (expq.size() != 0 && n < 4 * BITCLK) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain_%s: %0d words outstanding, required 0",
                     tag, expq.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("rst_data0", 32'(d0), 32'h0);
        check_eq("rst_data1", 32'(d1), 32'h0);
        check_eq("rst_data2", 32'(d2), 32'h0);
        check_eq("rst_done", 32'(done), 32'h0);
        check_eq("rst_flags", 32'({pe, fe, bd}), 32'h0);
        rst = 1'b0;
        idle(0, 2);

        expect_w(0, 9'h0A5, 1'b0, 1'b0, 1'b0);
        send(0, 8, 9'h0A5, 1'b0, 1'b0, 1, 1'b1);
        idle(0, 2);
        drain("8n1");

        expect_w(1, 9'h037, 1'b0, 1'b0, 1'b0);
        send(1, 8, 9'h037, 1'b1, 1'b1, 1, 1'b1);
        expect_w(1, 9'h037, 1'b1, 1'b0, 1'b0);
        send(1, 8, 9'h037, 1'b1, 1'b0, 1, 1'b1);
        expect_w(1, 9'h000, 1'b0, 1'b0, 1'b0);
        send(1, 8, 9'h000, 1'b1, 1'b0, 1, 1'b1);
        idle(1, 2);
        drain("8e1");

        rx[0] = 1'b0;
        repeat (8) @(negedge clk);
        rx[0] = 1'b1;
        idle(0, 3);
        check_eq("glitch_hold", 32'(d0), 32'hA5);

        expect_w(0, 9'h000, 1'b0, 1'b1, 1'b1);
        rx[0] = 1'b0;
        repeat (12 * BITCLK) @(negedge clk);
        idle(0, 2);
        drain("break");
        expect_w(0, 9'h05A, 1'b0, 1'b0, 1'b0);
        send(0, 8, 9'h05A, 1'b0, 1'b0, 1, 1'b1);
        idle(0, 2);
        drain("after_break");

        expect_w(2, 9'h041, 1'b0, 1'b1, 1'b0);
        send(2, 7, 9'h041, 1'b1, 1'b1, 2, 1'b0);
        idle(2, 2);
        expect_w(2, 9'h041, 1'b0, 1'b0, 1'b0);
        send(2, 7, 9'h041, 1'b1, 1'b1, 2, 1'b1);
        expect_w(2, 9'h041, 1'b1, 1'b0, 1'b0);
        send(2, 7, 9'h041, 1'b1, 1'b0, 2, 1'b1);
        expect_w(2, 9'h07F, 1'b0, 1'b0, 1'b0);
        send(2, 7, 9'h07F, 1'b1, 1'b0, 2, 1'b1);
        idle(2, 2);
        drain("7o2");

        bitout(0, 1'b0);
        repeat (3) bitout(0, 1'b0);
        rx[0] = 1'b1;
        repeat (BITCLK / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("rst_mid_data", 32'(d0), 32'h0);
        idle(0, 12);

        expect_w(0, 9'h03C, 1'b0, 1'b0, 1'b0);
        expect_w(0, 9'h000, 1'b0, 1'b0, 1'b0);
        expect_w(0, 9'h0FF, 1'b0, 1'b0, 1'b0);
        send(0, 8, 9'h03C, 1'b0, 1'b0, 1, 1'b1);
        send(0, 8, 9'h000, 1'b0, 1'b0, 1, 1'b1);
        send(0, 8, 9'h0FF, 1'b0, 1'b0, 1, 1'b1);
        idle(0, 2);
        drain("b2b");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised UART receiver for the UART/FIFO subsystem, driven by the shared oversampling baud tick. It supports configurable data width, oversampling ratio, optional parity and one or two stop bits. It reports parity errors, framing errors and line breaks alongside each received word. It feeds the RX FIFO write port directly: `rx_done` is the write strobe and `rx_data` is the write data.

## Interface
- `DATA_BITS`, default 8: data bits per frame, legal 5..9.
- `OVERSAMPLE`, default 16: ticks per bit period, even, legal 8..32.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: legal 1 or 2.

Ports:
- `clk` in, 1: system clock; all logic is on the rising edge.
- `rst` in, 1: reset, synchronous, active-high.
- `rx` in, 1: serial line, asynchronous, idle high.
- `tick` in, 1: one-`clk` pulse at baud × `OVERSAMPLE`.
- `rx_data` out, `DATA_BITS`: last received word, LSB first on the line.
- `rx_done` out, 1: one-`clk` pulse when a frame completes.
- `parity_err` out, 1: parity mismatch on the last frame; always 0 when `PARITY`=0.
- `frame_err` out, 1: a stop bit was sampled low on the last frame.
- `break_det` out, 1: the last frame was all-zero including its stop bits.

## Operation
- Input conditioning: `rx` passes through a 2-flop synchronizer (`rx_s`, reset value 1). All decisions use `rx_s`.
- Counters: `tick_cnt` is `$clog2(OVERSAMPLE)` bits wide and `bit_cnt` is 4 bits wide. Counters and state advance only in cycles where `tick`=1, except in IDLE and WAIT_IDLE.
- IDLE: when `rx_s`=0, clear `tick_cnt` and go to START.
- START: on each tick, increment `tick_cnt`. At the tick where `tick_cnt`==`OVERSAMPLE`/2-1, resample:
  - `rx_s`=0: go to DATA, `tick_cnt`=0, `bit_cnt`=0.
  - `rx_s`=1: false start, return to IDLE with no output activity.
- DATA: sample at the tick where `tick_cnt`==`OVERSAMPLE`-1 (bit centre).
  - Shift the sample into the MSB of the shift register and shift right, so the first bit lands in bit 0.
  - After `DATA_BITS` samples, go to PARITY if `PARITY`!=0, otherwise go to STOP.
- PARITY: sample at the bit centre. `par_bad` = XOR of the data bits and the parity bit, compared against the mode:
  - odd: XOR must be 1.
  - even: XOR must be 0.
- STOP: sample `STOP_BITS` bits at their centres and latch `stop_bad` if any sample is 0. After the last stop sample, in the same clk:
  - `rx_done_next`=1.
  - Load `rx_data`, `parity_err`, `frame_err` and `break_det` from the frame.
  - `break_det` = (data==0) && (parity bit==0 or no parity) && `stop_bad`.
  - Next state: IDLE if `stop_bad`=0, otherwise WAIT_IDLE.
- WAIT_IDLE: stay until `rx_s`=1, then go to IDLE. This prevents a held-low line (break) from being re-decoded as repeated 0x00 frames.
- `rx_data` and the three flags hold their values until the next `rx_done`. A false start, or a reset-free abort, never modifies them.
- Reset: state=IDLE, all counters 0, shift register 0, `rx_data`=0, `rx_done`=0, all flags 0, synchronizer flops = 1. If reset is asserted mid-frame, the frame is dropped: no `rx_done` for it.

## Timing
- `rx` to detection: 2-clk synchronizer latency, plus 1 clk for the IDLE→START transition.
- The start bit is validated `OVERSAMPLE`/2 ticks after detection; each subsequent bit is sampled `OVERSAMPLE` ticks after the previous one.
- `rx_done` goes high on the clk edge after the tick cycle of the last stop sample. It is exactly 1 clk wide, even when `tick` is asserted continuously.
- `rx_data` and the flags are valid in the same cycle as `rx_done`.
- Back-to-back frames: a start bit immediately following the stop bit(s) is accepted. IDLE re-arms in the cycle after `rx_done` when `frame_err`=0.
- `tick`=1 in every clk (tick rate equal to `clk`) is legal.

## Test plan
- 8N1, `OVERSAMPLE`=16: send 0xA5 → exactly one `rx_done`; `rx_data`=0xA5; `parity_err`=`frame_err`=`break_det`=0.
- 8E1: send 0x37 with a correct parity bit (1) → `parity_err`=0. Resend with the parity bit set to 0 → `parity_err`=1, `rx_data`=0x37.
- Glitch: hold `rx` low for 4 ticks, then high → no `rx_done`; `rx_data` keeps its prior value; the FSM returns to IDLE.
- Break: hold `rx` low for 12 bit times → one `rx_done` with `rx_data`=0, `frame_err`=1, `break_det`=1, and no further `rx_done` while low. Release high, then send 0x5A → `rx_data`=0x5A with all flags 0.
- 7O2 (`DATA_BITS`=7, odd parity, `STOP_BITS`=2): send 0x41 with the second stop bit forced to 0 → `frame_err`=1, `break_det`=0, `rx_data`=0x41.
- Assert `rst` for 1 clk during data bit 3 of one frame, then send 0x3C cleanly → exactly one `rx_done`, with `rx_data`=0x3C. Follow with back-to-back 0x00 and 0xFF frames, no idle gap → two `rx_done` pulses, data in order.
